muldiv_seq: RTL and testbench

Multi-cycle sequencer for the MIPS `mult` and `div` instructions. It runs radix-2 Booth signed multiplication and signed restoring division over a single shared 33-bit adder/subtractor. It hands the 64-bit result to the HI/LO registers through a one-cycle write strobe. The main control FSM starts it with a pulse and stalls until `done`, replacing the separate mult and div control blocks feeding the HI/LO muxes.

---
 rtl/muldiv_pkg.sv | 31 +++
 rtl/muldiv_seq_addsub33.sv | 20 ++
 rtl/muldiv_seq.sv | 228 ++++++++++++++++++++++
 tb/tb_muldiv_seq.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the mult/div sequencer.
//   - state_e        : sequencer states
//   - OP_MULT/OP_DIV : encoding of the op input
//   - MULDIV_WIDTH   : default operand width
//   - booth_* helpers: radix-2 Booth recoding of the {Q0,Q-1} pair
package muldiv_pkg;

    localparam int MULDIV_WIDTH = 32;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MULT = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_e;

    // 01 and 10 are the only pairs that touch the accumulator
    function automatic logic booth_active(input logic [1:0] pair);
        return pair[1] ^ pair[0];
    endfunction

    // 10 marks the start of a run of ones: subtract the multiplicand
    function automatic logic booth_sub(input logic [1:0] pair);
        return (pair == 2'b10);
    endfunction

endpackage

// File: rtl/muldiv_seq_addsub33.sv
// addsub33: the single adder/subtractor shared by Booth steps and the
// restoring-division trial subtract.
//   a_i, b_i : operands (W bits, two's complement)
//   sub_i    : 1 = a_i - b_i, 0 = a_i + b_i
//   sum_o    : W-bit result, carry-out dropped
module addsub33 #(
    parameter int W = 33
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         sub_i,
    output logic [W-1:0] sum_o
);

    // Subtract is add of the inverted operand with a carry-in of one
    always_comb begin
        sum_o = a_i + (b_i ^ {W{sub_i}}) + {{(W-1){1'b0}}, sub_i};
    end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle signed multiply (radix-2 Booth) and signed
// restoring divide for the MIPS mult/div instructions, sharing one adder.
//   clock, reset    : rising-edge clock, async active-low reset
//   start, op       : request pulse (sampled in IDLE), 0 = mult, 1 = div
//   opa, opb        : rs / rt operands, sampled with start
//   busy            : high whenever the sequencer is not in IDLE
//   done            : one-cycle completion pulse
//   div_zero        : with done, when a div had a zero divisor
//   wr_hilo         : with done on a valid result (HI/LO write enable)
//   hi_res, lo_res  : registered HI/LO result, held until the next write
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic             wr_hilo,
    output logic [WIDTH-1:0] hi_res,
    output logic [WIDTH-1:0] lo_res
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    // One extra bit: Booth accumulator sign extension / division trial sign
    localparam int AW    = WIDTH + 1;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    // a_q: multiplicand (mult) or divisor magnitude (div)
    logic [WIDTH-1:0] a_q;
    // acc_q: Booth accumulator (mult) or partial remainder in the low bits (div)
    logic [AW-1:0]    acc_q;
    // q_q: multiplier being shifted out (mult) or quotient being built (div)
    logic [WIDTH-1:0] q_q;
    logic             qm1_q;
    logic             sign_q_q;
    logic             sign_r_q;
    logic             dz_q;

    logic [AW-1:0]    add_a_s;
    logic [AW-1:0]    add_b_s;
    logic             add_sub_s;
    logic [AW-1:0]    sum_s;
    logic [AW-1:0]    acc_step_d;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] opa_mag_s;
    logic [WIDTH-1:0] opb_mag_s;

    addsub33 #(.W(AW)) u_addsub (
        .a_i   (add_a_s),
        .b_i   (add_b_s),
        .sub_i (add_sub_s),
        .sum_o (sum_s)
    );

    // Steer the shared adder: Booth add/sub in MULT, trial subtract in DIV
    always_comb begin
        add_a_s   = {AW{1'b0}};
        add_b_s   = {AW{1'b0}};
        add_sub_s = 1'b0;
        case (state_q)
            MULT: begin
                add_a_s   = acc_q;
                add_b_s   = {a_q[WIDTH-1], a_q};
                add_sub_s = booth_sub({q_q[0], qm1_q});
            end
            DIV: begin
                // {rem,quot} shifted left by one; remainder never exceeds WIDTH-1 bits
                add_a_s   = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
                add_b_s   = {1'b0, a_q};
                add_sub_s = 1'b1;
            end
            default: begin
                add_a_s   = {AW{1'b0}};
                add_b_s   = {AW{1'b0}};
                add_sub_s = 1'b0;
            end
        endcase
    end

    // Per-step next values derived from the adder output
    always_comb begin
        acc_step_d = acc_q;
        rem_d      = acc_q[WIDTH-1:0];
        opa_mag_s  = opa;
        opb_mag_s  = opb;
        if (booth_active({q_q[0], qm1_q})) begin
            acc_step_d = sum_s;
        end else begin
            acc_step_d = acc_q;
        end
        // Restore (keep the shifted value) when the trial went negative
        if (sum_s[AW-1]) begin
            rem_d = add_a_s[WIDTH-1:0];
        end else begin
            rem_d = sum_s[WIDTH-1:0];
        end
        if (opa[WIDTH-1]) begin
            opa_mag_s = -opa;
        end else begin
            opa_mag_s = opa;
        end
        if (opb[WIDTH-1]) begin
            opb_mag_s = -opb;
        end else begin
            opb_mag_s = opb;
        end
    end

    // Sequencer FSM, datapath registers and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            a_q      <= {WIDTH{1'b0}};
            acc_q    <= {AW{1'b0}};
            q_q      <= {WIDTH{1'b0}};
            qm1_q    <= 1'b0;
            sign_q_q <= 1'b0;
            sign_r_q <= 1'b0;
            dz_q     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            wr_hilo  <= 1'b0;
            hi_res   <= {WIDTH{1'b0}};
            lo_res   <= {WIDTH{1'b0}};
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            wr_hilo  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cnt_q <= CNT_LOAD;
                        acc_q <= {AW{1'b0}};
                        qm1_q <= 1'b0;
                        busy  <= 1'b1;
                        if (op == OP_MULT) begin
                            a_q     <= opa;
                            q_q     <= opb;
                            dz_q    <= 1'b0;
                            state_q <= MULT;
                        end else if (opb == {WIDTH{1'b0}}) begin
                            dz_q    <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            a_q      <= opb_mag_s;
                            q_q      <= opa_mag_s;
                            sign_q_q <= opa[WIDTH-1] ^ opb[WIDTH-1];
                            sign_r_q <= opa[WIDTH-1];
                            dz_q     <= 1'b0;
                            state_q  <= DIV;
                        end
                    end else begin
                        busy    <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                MULT: begin
                    // Arithmetic right shift of {acc, Q, Q-1}
                    acc_q <= {acc_step_d[AW-1], acc_step_d[AW-1:1]};
                    q_q   <= {acc_step_d[0], q_q[WIDTH-1:1]};
                    qm1_q <= q_q[0];
                    cnt_q <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_q <= DONE;
                    end else begin
                        state_q <= MULT;
                    end
                end
                DIV: begin
                    acc_q <= {1'b0, rem_d};
                    q_q   <= {q_q[WIDTH-2:0], ~sum_s[AW-1]};
                    cnt_q <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_q <= FIX;
                    end else begin
                        state_q <= DIV;
                    end
                end
                FIX: begin
                    // Quotient truncates toward zero; remainder follows the dividend
                    if (sign_r_q) begin
                        acc_q <= {1'b0, -acc_q[WIDTH-1:0]};
                    end else begin
                        acc_q <= acc_q;
                    end
                    if (sign_q_q) begin
                        q_q <= -q_q;
                    end else begin
                        q_q <= q_q;
                    end
                    state_q <= DONE;
                end
                DONE: begin
                    done     <= 1'b1;
                    div_zero <= dz_q;
                    wr_hilo  <= ~dz_q;
                    if (!dz_q) begin
                        hi_res <= acc_q[WIDTH-1:0];
                        lo_res <= q_q;
                    end else begin
                        hi_res <= hi_res;
                        lo_res <= lo_res;
                    end
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: self-checking bench for muldiv_seq. Directed cases,
// randomized mult/div traffic against a plain-arithmetic reference model,
// handshake (ignored starts, held start) and mid-operation reset.
module tb_muldiv_seq;

    logic        clock;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic        wr_hilo;
    logic [31:0] hi_res;
    logic [31:0] lo_res;

    int checks = 0;
    int errors = 0;

    // Architectural HI/LO as the reference sees them
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    muldiv_seq dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .opa      (opa),
        .opb      (opb),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .wr_hilo  (wr_hilo),
        .hi_res   (hi_res),
        .lo_res   (lo_res)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: signed 64-bit arithmetic; SV '/' truncates toward zero, '%' follows dividend
    function automatic logic [63:0] ref_result(input logic o, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint p;
        longint q;
        longint r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!o) begin
            p = sa * sb;
            return p;
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Waits (bounded) for done after the start edge; returns edges counted
    task automatic wait_done(output int k, output bit seen, input bit disturb);
        k = 0;
        seen = 1'b0;
        while (!seen && k < 80) begin
            @(posedge clock);
            k++;
            #1;
            if (disturb) begin
                if (k == 5 || k == 20) begin
                    start = 1'b1;
                    op    = 1'b1;
                    opb   = 32'h0;
                end else begin
                    start = 1'b0;
                end
                if (k == 10) check_eq("busy_mid", {63'd0, busy}, 64'd1);
            end
            if (done) seen = 1'b1;
        end
        check_eq("done_seen", {63'd0, seen}, 64'd1);
    endtask

    task automatic check_result(input logic o, input logic [31:0] a, input logic [31:0] b,
                                input int k);
        logic        dz;
        logic [63:0] r;
        dz = o && (b == 32'h0);
        if (!dz) begin
            r    = ref_result(o, a, b);
            m_hi = r[63:32];
            m_lo = r[31:0];
        end
        check_eq("latency", 64'(k), dz ? 64'd1 : (o ? 64'd34 : 64'd33));
        check_eq("wr_hilo", {63'd0, wr_hilo}, {63'd0, ~dz});
        check_eq("div_zero", {63'd0, div_zero}, {63'd0, dz});
        check_eq("busy_at_done", {63'd0, busy}, 64'd0);
        check_eq("hilo", {hi_res, lo_res}, {m_hi, m_lo});
    endtask

    task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b, input bit disturb);
        int k;
        bit seen;
        @(negedge clock);
        start = 1'b1;
        op    = o;
        opa   = a;
        opb   = b;
        @(posedge clock);
        #1;
        start = 1'b0;
        opa   = $urandom;
        opb   = $urandom;
        op    = ~o;
        check_eq("busy_rise", {63'd0, busy}, 64'd1);
        wait_done(k, seen, disturb);
        check_result(o, a, b, k);
        @(posedge clock);
        #1;
        check_eq("done_pulse", {62'd0, done, wr_hilo}, 64'd0);
    endtask

    initial begin
        int          k;
        bit          seen;
        int          n_done;
        logic [31:0] a;
        logic [31:0] b;
        logic        o;
        int          sel;

        reset = 1'b0;
        start = 1'b0;
        op    = 1'b0;
        opa   = 32'h0;
        opb   = 32'h0;
        m_hi  = 32'h0;
        m_lo  = 32'h0;
        repeat (2) @(posedge clock);
        #1;
        check_eq("reset_ctl", {60'd0, busy, done, div_zero, wr_hilo}, 64'd0);
        check_eq("reset_hilo", {hi_res, lo_res}, 64'd0);
        @(negedge clock);
        reset = 1'b1;

        // Directed cases
        run_op(1'b0, 32'h00000007, 32'hFFFFFFFD, 1'b0);
        check_eq("m7x-3", {hi_res, lo_res}, 64'hFFFFFFFF_FFFFFFEB);
        run_op(1'b0, 32'h80000000, 32'h80000000, 1'b0);
        check_eq("mminxmin", {hi_res, lo_res}, 64'h40000000_00000000);
        run_op(1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0);
        check_eq("mmaxxmax", {hi_res, lo_res}, 64'h3FFFFFFF_00000001);
        run_op(1'b1, 32'hFFFFFFF9, 32'h00000002, 1'b0);
        check_eq("d-7/2", {hi_res, lo_res}, 64'hFFFFFFFF_FFFFFFFD);
        run_op(1'b1, 32'h00000007, 32'hFFFFFFFE, 1'b0);
        check_eq("d7/-2", {hi_res, lo_res}, 64'h00000001_FFFFFFFD);
        run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        check_eq("dmin/-1", {hi_res, lo_res}, 64'h00000000_80000000);
        // 0x55555556 * 0x33333333 = 0x11111111_22222222
        run_op(1'b0, 32'h55555556, 32'h33333333, 1'b0);
        check_eq("preload", {hi_res, lo_res}, 64'h11111111_22222222);
        run_op(1'b1, 32'h00000005, 32'h00000000, 1'b0);
        check_eq("dz_hold", {hi_res, lo_res}, 64'h11111111_22222222);

        // Stray div starts during a mult must be ignored
        run_op(1'b0, 32'h0001E240, 32'hFFFF8000, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 24; i++) begin
            o   = 1'($urandom_range(0, 1));
            a   = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) begin
                b = 32'h0;
            end else if (sel == 1) begin
                b = 32'($urandom_range(1, 9));
                if ($urandom_range(0, 1) == 1) b = -b;
            end else begin
                b = $urandom;
            end
            if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 20));
            run_op(o, a, b, 1'b0);
        end

        // Start held high through DONE launches exactly one new operation
        @(negedge clock);
        start = 1'b1;
        op    = 1'b0;
        opa   = 32'h00001234;
        opb   = 32'hFFFFF000;
        @(posedge clock);
        #1;
        wait_done(k, seen, 1'b0);
        check_result(1'b0, 32'h00001234, 32'hFFFFF000, k);
        opa = 32'hDEADBEEF;
        opb = 32'h00000101;
        @(posedge clock);
        #1;
        start = 1'b0;
        check_eq("held_relaunch", {63'd0, busy}, 64'd1);
        wait_done(k, seen, 1'b0);
        check_result(1'b0, 32'hDEADBEEF, 32'h00000101, k);
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (done) n_done++;
        end
        check_eq("held_single", 64'(n_done), 64'd0);

        // Reset in the middle of a divide
        @(negedge clock);
        start = 1'b1;
        op    = 1'b1;
        opa   = 32'hFFFFFF9C;
        opb   = 32'h00000007;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check_eq("rst_mid_ctl", {60'd0, busy, done, div_zero, wr_hilo}, 64'd0);
        check_eq("rst_mid_hilo", {hi_res, lo_res}, 64'd0);
        n_done = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            if (wr_hilo || done) n_done++;
        end
        check_eq("rst_no_write", 64'(n_done), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        m_hi  = 32'h0;
        m_lo  = 32'h0;
        run_op(1'b0, 32'hFFFFFFF0, 32'h00000011, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
